// File: rtl/dffe_monitor.sv
// dffe_monitor
//   Watches an external enable flip-flop (D, EN -> Q) and checks that it
//   behaves like an ideal DFFE. A shadow register EXP follows D on every
//   EN=1 edge. Once EXP holds a known value, every edge compares the current
//   Q against EXP as it was before that edge.
//
//   Optional feature: define DFFE_MON_HOLD_CHECK_EN to add the HOLD_ERR
//   output. It flags Q changing between two consecutive compare edges when
//   EN was 0 at the earlier one.
//
// Ports
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-high reset
//   D/EN/Q   in   data, enable and output of the monitored flip-flop
//   CLR_ERR  in   pulse: clears ERR_CNT; leaves FAIL if no mismatch this edge
//   PRIMED   out  shadow value is valid (FSM not UNPRIMED)
//   ERR      out  sticky mismatch flag (FSM in FAIL)
//   ERR_CNT  out  saturating count of mismatching compare edges
//   CAP_CNT  out  saturating count of EN=1 edges
//   ERR_EXP  out  expected value at the most recent mismatch
//   ERR_GOT  out  observed Q at the most recent mismatch
//   HOLD_ERR out  sticky hold violation flag (only with the macro)
module dffe_monitor #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic [WIDTH-1:0] Q,
  input  logic             CLR_ERR,
  output logic             PRIMED,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] CAP_CNT,
  output logic [WIDTH-1:0] ERR_EXP,
  output logic [WIDTH-1:0] ERR_GOT
`ifdef DFFE_MON_HOLD_CHECK_EN
  ,
  output logic             HOLD_ERR
`endif
);

  typedef enum logic [1:0] {UNPRIMED = 2'd0, TRACK = 2'd1, FAIL = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, cap_cnt_q, cap_cnt_d;
  logic [CNT_W-1:0] err_cnt_base;
  logic [WIDTH-1:0] err_exp_q, err_exp_d, err_got_q, err_got_d;
  logic             cmp, mismatch, err_evt;

`ifdef DFFE_MON_HOLD_CHECK_EN
  // Previous compare edge: was it a compare edge, what was EN, what was Q.
  logic             prev_cmp_q, prev_cmp_d, prev_en_q, prev_en_d;
  logic [WIDTH-1:0] prev_q_q, prev_q_d;
  logic             hold_err_q, hold_err_d, hold_viol;
`endif

  always_comb begin
    // Compare uses EXP as it stood before this edge.
    cmp      = (state_q != UNPRIMED);
    mismatch = cmp && (Q != exp_q);
`ifdef DFFE_MON_HOLD_CHECK_EN
    hold_viol  = cmp && prev_cmp_q && !prev_en_q && (Q != prev_q_q);
    err_evt    = mismatch || hold_viol;
    prev_cmp_d = cmp;
    prev_en_d  = EN;
    prev_q_d   = Q;
    // Set beats clear, same as the mismatch-vs-CLR_ERR rule for ERR.
    hold_err_d = hold_viol ? 1'b1 : (CLR_ERR ? 1'b0 : hold_err_q);
`else
    err_evt    = mismatch;
`endif

    state_d = state_q;
    unique case (state_q)
      UNPRIMED: if (EN) state_d = TRACK;
      TRACK:    if (mismatch) state_d = FAIL;
      FAIL:     if (!mismatch && CLR_ERR) state_d = TRACK;
      default:  state_d = UNPRIMED;
    endcase

    exp_d = EN ? D : exp_q;

    cap_cnt_d = (EN && cap_cnt_q != CNT_MAX) ? cap_cnt_q + CNT_W'(1) : cap_cnt_q;

    // Clear first, then count: a mismatch on the clearing edge leaves 1.
    err_cnt_base = CLR_ERR ? '0 : err_cnt_q;
    err_cnt_d    = (err_evt && err_cnt_base != CNT_MAX) ? err_cnt_base + CNT_W'(1)
                                                        : err_cnt_base;

    err_exp_d = mismatch ? exp_q : err_exp_q;
    err_got_d = mismatch ? Q     : err_got_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= UNPRIMED;
      exp_q     <= '0;
      err_cnt_q <= '0;
      cap_cnt_q <= '0;
      err_exp_q <= '0;
      err_got_q <= '0;
`ifdef DFFE_MON_HOLD_CHECK_EN
      prev_cmp_q <= 1'b0;
      prev_en_q  <= 1'b0;
      prev_q_q   <= '0;
      hold_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      err_cnt_q <= err_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      err_exp_q <= err_exp_d;
      err_got_q <= err_got_d;
`ifdef DFFE_MON_HOLD_CHECK_EN
      prev_cmp_q <= prev_cmp_d;
      prev_en_q  <= prev_en_d;
      prev_q_q   <= prev_q_d;
      hold_err_q <= hold_err_d;
`endif
    end
  end

  // Every output is a flop or a decode of the state flop only.
  assign PRIMED  = (state_q != UNPRIMED);
  assign ERR     = (state_q == FAIL);
  assign ERR_CNT = err_cnt_q;
  assign CAP_CNT = cap_cnt_q;
  assign ERR_EXP = err_exp_q;
  assign ERR_GOT = err_got_q;
`ifdef DFFE_MON_HOLD_CHECK_EN
  assign HOLD_ERR = hold_err_q;
`endif

endmodule

// File: tb/tb_dffe_monitor.sv
module tb_dffe_monitor;

  localparam int W  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0, en = 1'b0, clr_err = 1'b0;
  logic [W-1:0]  d = '0, q = '0;
  logic          primed, err;
  logic [CW-1:0] err_cnt, cap_cnt;
  logic [W-1:0]  err_exp, err_got;
`ifdef DFFE_MON_HOLD_CHECK_EN
  logic          hold_err;
`endif

  dffe_monitor #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK(clk), .RST(rst), .D(d), .EN(en), .Q(q), .CLR_ERR(clr_err),
    .PRIMED(primed), .ERR(err), .ERR_CNT(err_cnt), .CAP_CNT(cap_cnt),
    .ERR_EXP(err_exp), .ERR_GOT(err_got)
`ifdef DFFE_MON_HOLD_CHECK_EN
    , .HOLD_ERR(hold_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  chk;
    string nm;
    int    primed, err, ecnt, ccnt, eexp, egot;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Drive one edge worth of inputs and queue what the outputs must be after it.
  task automatic step(input logic r, input logic e, input int dv, input int qv,
                      input logic c, input string nm, input int p, input int er,
                      input int ec, input int cc, input int ee, input int eg);
    exp_t x;
    rst = r; en = e; d = W'(dv); q = W'(qv); clr_err = c;
    x.chk = 1'b1; x.nm = nm; x.primed = p; x.err = er;
    x.ecnt = ec; x.ccnt = cc; x.eexp = ee; x.egot = eg;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one queued expectation per edge, checked on the falling edge.
  task automatic cmp(input string nm, input string fld, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s.%s: got %0d expected %0d", nm, fld, got, want);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      if (x.chk) begin
        cmp(x.nm, "PRIMED",  int'(primed),  x.primed);
        cmp(x.nm, "ERR",     int'(err),     x.err);
        cmp(x.nm, "ERR_CNT", int'(err_cnt), x.ecnt);
        cmp(x.nm, "CAP_CNT", int'(cap_cnt), x.ccnt);
        cmp(x.nm, "ERR_EXP", int'(err_exp), x.eexp);
        cmp(x.nm, "ERR_GOT", int'(err_got), x.egot);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then idle with EN=0 and D toggling: nothing may move.
    //    rst en  d  q  clr  name       pr er ec cc ee eg
    step(1, 0, 0, 0, 0, "reset",      0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step(0, 0, i % 4, 0, 0, "idle",  0, 0, 0, 0, 0, 0);

    // Correct DFFE stream: Q lags D by one EN edge.
    step(0, 1, 0, 0, 0, "prime",      1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0, "track1",     1, 0, 0, 2, 0, 0);
    step(0, 1, 2, 1, 0, "track2",     1, 0, 0, 3, 0, 0);
    step(0, 1, 3, 2, 0, "track3",     1, 0, 0, 4, 0, 0);
    // CLR_ERR in TRACK is harmless; CAP_CNT untouched.
    step(0, 0, 0, 3, 1, "clr_track",  1, 0, 0, 4, 0, 0);

    // Load EXP=10, hold, then Q glitches to 01 for one edge.
    step(0, 1, 2, 3, 0, "load10",     1, 0, 0, 5, 0, 0);
    step(0, 0, 0, 2, 0, "hold_ok",    1, 0, 0, 5, 0, 0);
    step(0, 0, 0, 1, 0, "glitch",     1, 1, 1, 5, 2, 1);
    step(0, 0, 0, 2, 0, "fail_stay",  1, 1, 1, 5, 2, 1);

    // CLR_ERR with Q correct leaves FAIL, capture regs retained.
    step(0, 0, 0, 2, 1, "clr_ok",     1, 0, 0, 5, 2, 1);
    step(0, 0, 0, 3, 0, "mis2",       1, 1, 1, 5, 2, 3);
    // CLR_ERR together with a mismatch: mismatch wins.
    step(0, 0, 0, 0, 1, "clr_vs_mis", 1, 1, 1, 5, 2, 0);
    step(0, 0, 0, 2, 0, "fail_hold",  1, 1, 1, 5, 2, 0);

    // Reset mid-stream with Q wrong overrides EN/D; no compare until primed again.
    step(1, 1, 3, 1, 0, "rst_mid",    0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 3, 0, "unprimed",   0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 3, 0, "reprime",    1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 3, 0, "first_cmp",  1, 1, 1, 1, 1, 3);

    // Saturation with a 4-bit counter: EN=1 for 20 edges, Q always wrong.
    step(1, 0, 0, 0, 0, "reset2",     0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      int pd, qv, ee, eg;
      pd = (i + 3) % 4;                 // D of the previous edge (EXP)
      qv = (i == 0) ? 0 : (pd ^ 3);
      ee = (i == 0) ? 0 : pd;
      eg = (i == 0) ? 0 : (pd ^ 3);
      step(0, 1, i % 4, qv, 0, "sat", 1, (i >= 1) ? 1 : 0,
           (i > 15) ? 15 : i, (i + 1 > 15) ? 15 : i + 1, ee, eg);
    end

    en = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
